obi_arbiter_2to1: RTL
=====================

Name: obi_arbiter_2to1

Overview:
Shares one OBI-style memory port (e.g. boot ROM or on-chip RAM) between the core instruction port (master 0, read-only) and data port (master 1). Arbitration is round-robin, with requests held stable across wait states. An ID FIFO routes each rvalid back to the master that issued it. The block adds zero latency on both the request and response paths.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTSTANDING, 2, depth of the in-flight ID FIFO (power of 2, >=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
m0_req_i  in  1  instr master request
m0_gnt_o  out  1  instr master grant
m0_rvalid_o  out  1  instr response valid
m0_addr_i  in  ADDR_W  instr address
m1_req_i  in  1  data master request
m1_gnt_o  out  1  data master grant
m1_rvalid_o  out  1  data response valid
m1_addr_i  in  ADDR_W  data address
m1_we_i  in  1  data write enable
m1_be_i  in  DATA_W/8  data byte enables
m1_wdata_i  in  DATA_W  data write data
rsp_rdata_o  out  DATA_W  read data, broadcast to both masters (qualified by mX_rvalid_o)
rsp_err_o  out  1  error, broadcast (qualified by mX_rvalid_o)
s_req_o  out  1  slave request
s_gnt_i  in  1  slave grant (may be combinational on s_req_o/s_addr_o)
s_rvalid_i  in  1  slave response valid
s_addr_o  out  ADDR_W  slave address
s_we_o  out  1  slave write enable (0 when m0 selected)
s_be_o  out  DATA_W/8  slave byte enables (all ones when m0 selected)
s_wdata_o  out  DATA_W  slave write data (0 when m0 selected)
s_rdata_i  in  DATA_W  slave read data
s_err_i  in  1  slave error
protocol_err_o  out  1  sticky: rvalid received with no transaction outstanding

Behaviour:
- Registered state: prio (0 = m0 favoured), lock, lock_id, ID FIFO (wr/rd pointers, count 0..MAX_OUTSTANDING), protocol_err. Reset: prio=0, lock=0, count=0, pointers=0, protocol_err=0.
- All outputs are combinational from state and inputs. With no requests pending, every output is 0 except s_be_o, which shows all ones (m0 selected by default).
- full = (count==MAX_OUTSTANDING). s_req_o = (m0_req_i|m1_req_i) & ~full.
- Winner selection:
  - If lock=1: winner = lock_id.
  - Otherwise, if only one master requests, it wins.
  - If both request: winner = m0 when prio=0, m1 when prio=1.
- Mux the winner's addr/we/be/wdata onto s_*.
- Grant: mX_gnt_o = s_req_o & s_gnt_i & (winner==X). At most one grant per cycle.
- Lock: if s_req_o & ~s_gnt_i, set lock=1 and lock_id=winner. Clear lock on handshake. This keeps OBI address-phase signals stable during wait states.
- Handshake (s_req_o & s_gnt_i):
  - Push winner into the FIFO.
  - prio <= ~winner (last-served master drops to lower priority).
  - With a single requester, prio still updates.
- Response:
  - If s_rvalid_i & count>0: pop the head and assert m<head>_rvalid_o the same cycle. rsp_rdata_o = s_rdata_i, rsp_err_o = s_err_i, both passed through unconditionally.
  - If s_rvalid_i & count==0: drop (no mX_rvalid_o), set protocol_err=1 until reset.
- Simultaneous push and pop: count unchanged, and both pointers advance.
- At full, no new request is issued even if a pop occurs the same cycle. full is evaluated on the registered count. For the 1-cycle-rvalid ROM, MAX_OUTSTANDING=2 sustains 1 transfer/cycle.
- Pointer wrap: modulo MAX_OUTSTANDING, with count as the separate full/empty discriminator.
- Reset mid-operation: the FIFO is flushed and in-flight responses are lost. Slave and masters are reset on the same rst, so no orphan rvalid is expected.

Decomposition:
- Package obi_pkg: obi_req_t struct (req, addr, we, be, wdata), obi_rsp_t struct (gnt, rvalid, rdata, err), typedef master_id_t (1 bit), constants M_INSTR=0, M_DATA=1.
- Sub-module id_fifo (width 1, depth MAX_OUTSTANDING, push/pop/full/empty/head, async active-low reset).

Test Plan:
- m0 alone requests 0x80 with s_gnt_i=1; ROM returns 0x00000513 next cycle -> m0_gnt_o at cycle 0, m0_rvalid_o with rdata 0x00000513 at cycle 1, m1_rvalid_o=0.
- After reset, m0 and m1 request continuously -> grants alternate m0,m1,m0,m1. Each rvalid is routed to the matching master in issue order.
- m1 write (addr 0x40, be 4'b0011, wdata 0xDEADBEEF) with s_gnt_i held 0 for 3 cycles while m0 also requests:
  - s_addr_o/s_we_o/s_be_o/s_wdata_o stay on m1 all 3 cycles.
  - m1_gnt_o pulses on the cycle s_gnt_i rises.
  - m0 is served next.
- MAX_OUTSTANDING=2, s_rvalid_i withheld, both masters requesting -> exactly 2 grants, then s_req_o=0. One rvalid re-enables s_req_o the following cycle.
- s_rvalid_i pulsed with empty FIFO -> no mX_rvalid_o, protocol_err_o=1 and remaining 1 until rst low.
- rst asserted with 2 transactions outstanding -> count=0, lock=0, prio=0, protocol_err_o=0 immediately. First post-reset simultaneous request is granted to m0.

Source files
------------

// File: rtl/obi_pkg.sv
// Shared types for the OBI 2:1 arbiter: request/response bundles and master IDs.
package obi_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = OBI_DATA_W / 8;

    typedef logic master_id_t;

    localparam master_id_t M_INSTR = 1'b0;
    localparam master_id_t M_DATA  = 1'b1;

    typedef struct packed {
        logic                  req;
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_rsp_t;

endpackage

// File: rtl/obi_arbiter_2to1_if.sv
// Bus bundle between the two OBI masters, the arbiter and the shared slave port.
interface obi_arbiter_2to1_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m0_req_i;
    logic                  m0_gnt_o;
    logic                  m0_rvalid_o;
    logic [ADDR_W-1:0]     m0_addr_i;
    logic                  m1_req_i;
    logic                  m1_gnt_o;
    logic                  m1_rvalid_o;
    logic [ADDR_W-1:0]     m1_addr_i;
    logic                  m1_we_i;
    logic [DATA_W/8-1:0]   m1_be_i;
    logic [DATA_W-1:0]     m1_wdata_i;
    logic [DATA_W-1:0]     rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  s_req_o;
    logic                  s_gnt_i;
    logic                  s_rvalid_i;
    logic [ADDR_W-1:0]     s_addr_o;
    logic                  s_we_o;
    logic [DATA_W/8-1:0]   s_be_o;
    logic [DATA_W-1:0]     s_wdata_o;
    logic [DATA_W-1:0]     s_rdata_i;
    logic                  s_err_i;

    // The arbiter sits on the slave side of the masters and drives the shared port.
    modport slave (
        input  m0_req_i, m0_addr_i,
        input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
        output m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o,
        output rsp_rdata_o, rsp_err_o,
        output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );

    modport master (
        output m0_req_i, m0_addr_i,
        output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
        input  m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o,
        input  rsp_rdata_o, rsp_err_o,
        input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );

endinterface

// File: rtl/id_fifo.sv
// Small FIFO of master IDs, one entry per transaction granted but not yet answered.
module id_fifo
    import obi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  master_id_t push_id,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output master_id_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    master_id_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Count is the sole full/empty discriminator; pointers just wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Round-robin 2:1 OBI arbiter with locked wait states and in-order response routing.
module obi_arbiter_2to1
    import obi_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    obi_arbiter_2to1_if.slave       bus,
    output logic                    protocol_err_o
);

    obi_req_t   m0_req;
    obi_req_t   m1_req;
    obi_req_t   sel_req;
    obi_rsp_t   slv_rsp;
    master_id_t winner;
    master_id_t prio;
    master_id_t lock_id;
    master_id_t head;
    logic       lock;
    logic       full;
    logic       empty;
    logic       any_req;
    logic       handshake;
    logic       pop;
    logic       protocol_err;

    always_comb begin
        m0_req.req    = bus.m0_req_i;
        m0_req.addr   = OBI_ADDR_W'(bus.m0_addr_i);
        m0_req.we     = 1'b0;
        m0_req.be     = '1;
        m0_req.wdata  = '0;
        m1_req.req    = bus.m1_req_i;
        m1_req.addr   = OBI_ADDR_W'(bus.m1_addr_i);
        m1_req.we     = bus.m1_we_i;
        m1_req.be     = OBI_BE_W'(bus.m1_be_i);
        m1_req.wdata  = OBI_DATA_W'(bus.m1_wdata_i);
        slv_rsp.gnt    = bus.s_gnt_i;
        slv_rsp.rvalid = bus.s_rvalid_i;
        slv_rsp.rdata  = OBI_DATA_W'(bus.s_rdata_i);
        slv_rsp.err    = bus.s_err_i;
    end

    assign any_req = m0_req.req | m1_req.req;

    // A stalled request keeps its winner so the address phase stays stable.
    always_comb begin
        winner = M_INSTR;
        if (lock) begin
            winner = lock_id;
        end else if (m0_req.req && m1_req.req) begin
            winner = prio;
        end else if (m1_req.req) begin
            winner = M_DATA;
        end
    end

    always_comb begin
        sel_req = m0_req;
        if (winner == M_DATA) begin
            sel_req = m1_req;
        end
        if (!any_req) begin
            sel_req.addr = '0;
        end
        sel_req.req = any_req & ~full;
    end

    assign handshake = sel_req.req & slv_rsp.gnt;
    assign pop       = slv_rsp.rvalid & ~empty;

    assign bus.s_req_o     = sel_req.req;
    assign bus.s_addr_o    = ADDR_W'(sel_req.addr);
    assign bus.s_we_o      = sel_req.we;
    assign bus.s_be_o      = (DATA_W/8)'(sel_req.be);
    assign bus.s_wdata_o   = DATA_W'(sel_req.wdata);
    assign bus.m0_gnt_o    = handshake & (winner == M_INSTR);
    assign bus.m1_gnt_o    = handshake & (winner == M_DATA);
    assign bus.m0_rvalid_o = pop & (head == M_INSTR);
    assign bus.m1_rvalid_o = pop & (head == M_DATA);
    assign bus.rsp_rdata_o = DATA_W'(slv_rsp.rdata);
    assign bus.rsp_err_o   = slv_rsp.err;
    assign protocol_err_o  = protocol_err;

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (handshake),
        .push_id (winner),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio         <= M_INSTR;
            lock         <= 1'b0;
            lock_id      <= M_INSTR;
            protocol_err <= 1'b0;
        end else begin
            if (handshake) begin
                prio <= ~winner;
                lock <= 1'b0;
            end else if (sel_req.req) begin
                lock    <= 1'b1;
                lock_id <= winner;
            end
            if (slv_rsp.rvalid && empty) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule
